// File: rtl/debug_dump_tx_pkg.sv
// Shared debug-unit definitions: FSM states, stream sections and word/byte sizing helpers.
// Used by both the dump transmitter and the debug receive/load path.
package debug_dump_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CAPTURE_PC = 3'd1,
        ST_READ       = 3'd2,
        ST_WAIT       = 3'd3,
        ST_SEND       = 3'd4,
        ST_DONE       = 3'd5,
        ST_CHECKSUM   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SEC_PC  = 2'd0,
        SEC_REG = 2'd1,
        SEC_MEM = 2'd2
    } section_e;

    localparam int DEFAULT_NB_DATA      = 32;
    localparam int DEFAULT_NB_MEM_WIDTH = 8;
    localparam int BYTES_PER_WORD       = DEFAULT_NB_DATA / DEFAULT_NB_MEM_WIDTH;

    function automatic int bytesPerWord(input int nbWord, input int nbByte);
        return nbWord / nbByte;
    endfunction

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debug_dump_tx_if.sv
// Outbound byte stream from the debug dump to the UART transmitter (valid/ready).
interface debug_dump_tx_if #(
    parameter int NB_MEM_WIDTH = 8
) ();

    logic [NB_MEM_WIDTH-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/debug_dump_tx_word_serializer.sv
// Loads a left-aligned word and shifts it out MSB byte first under valid/ready,
// pulsing wordLast_o on acceptance of the final byte.
module debug_word_serializer
    import debug_dump_tx_pkg::*;
#(
    parameter int NB_WORD      = 32,
    parameter int NB_MEM_WIDTH = 8,
    localparam int MAX_BYTES   = bytesPerWord(NB_WORD, NB_MEM_WIDTH),
    localparam int CNT_W       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [NB_WORD-1:0]      word_i,
    input  logic [CNT_W-1:0]        lastByte_i,
    input  logic                    txReady_i,
    output logic [NB_MEM_WIDTH-1:0] txData_o,
    output logic                    txValid_o,
    output logic                    wordLast_o
);

    logic [NB_WORD-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   byteCnt_q, byteCnt_d;
    logic [CNT_W-1:0]   lastIdx_q, lastIdx_d;
    logic               valid_q, valid_d;
    logic               accept;
    logic               isLast;

    assign accept = valid_q && txReady_i;
    assign isLast = (byteCnt_q == lastIdx_q);

    always_comb begin
        shift_d   = shift_q;
        byteCnt_d = byteCnt_q;
        lastIdx_d = lastIdx_q;
        valid_d   = valid_q;
        if (load_i) begin
            shift_d   = word_i;
            byteCnt_d = '0;
            lastIdx_d = lastByte_i;
            valid_d   = 1'b1;
        end else if (accept) begin
            shift_d = shift_q << NB_MEM_WIDTH;
            if (isLast) begin
                byteCnt_d = '0;
                valid_d   = 1'b0;
            end else begin
                byteCnt_d = byteCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q   <= '0;
            byteCnt_q <= '0;
            lastIdx_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            byteCnt_q <= byteCnt_d;
            lastIdx_q <= lastIdx_d;
            valid_q   <= valid_d;
        end
    end

    assign txData_o   = shift_q[NB_WORD-1 -: NB_MEM_WIDTH];
    assign txValid_o  = valid_q;
    assign wordLast_o = accept && isLast;

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: streams PC, the register bank and the first data-memory words as bytes.
// Optional macro DEBUG_DUMP_CHECKSUM_EN appends one XOR checksum byte after the memory section.
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int NB_PC        = 32,
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_ADDR      = 32,
    parameter int NB_MEM_WIDTH = 8,
    parameter int N_MEM_WORDS  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_PC-1:0]   i_pc,
    output logic [NB_REG-1:0]  o_reg_addr,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic               o_mem_read_enable,
    output logic [NB_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0] i_mem_data,
    debug_dump_tx_if.master    tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_WORD    = maxInt(NB_PC, NB_DATA);
    localparam int BYTES_PC   = bytesPerWord(NB_PC, NB_MEM_WIDTH);
    localparam int BYTES_DATA = bytesPerWord(NB_DATA, NB_MEM_WIDTH);
    localparam int MAX_BYTES  = bytesPerWord(NB_WORD, NB_MEM_WIDTH);
    localparam int CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int IDX_W      = maxInt(NB_REG, $clog2(N_MEM_WORDS)) + 1;
    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'((2 ** NB_REG) - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(N_MEM_WORDS - 1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam state_e AFTER_MEM = ST_CHECKSUM;
`else
    localparam state_e AFTER_MEM = ST_DONE;
`endif

    state_e             state_q, state_d;
    section_e           section_q, section_d;
    logic [IDX_W-1:0]   index_q, index_d;

    logic                    serLoad;
    logic [NB_WORD-1:0]      serWord;
    logic [CNT_W-1:0]        serLast;
    logic [NB_MEM_WIDTH-1:0] serData;
    logic                    serValid;
    logic                    serWordLast;

    // Words narrower than the serializer are left-aligned so the MSB byte always leaves first
    logic [NB_WORD-1:0] pcWord, regWord, memWord;
    assign pcWord  = NB_WORD'(i_pc) << (NB_WORD - NB_PC);
    assign regWord = NB_WORD'(i_reg_data) << (NB_WORD - NB_DATA);
    assign memWord = NB_WORD'(i_mem_data) << (NB_WORD - NB_DATA);

    always_comb begin
        state_d   = state_q;
        section_d = section_q;
        index_d   = index_q;
        serLoad   = 1'b0;
        serWord   = '0;
        serLast   = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    serLoad   = 1'b1;
                    serWord   = pcWord;
                    serLast   = CNT_W'(BYTES_PC - 1);
                    section_d = SEC_PC;
                    index_d   = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                serLoad = 1'b1;
                serWord = (section_q == SEC_REG) ? regWord : memWord;
                serLast = CNT_W'(BYTES_DATA - 1);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (serWordLast) begin
                    state_d = ST_READ;
                    case (section_q)
                        SEC_PC: begin
                            section_d = SEC_REG;
                            index_d   = '0;
                        end
                        SEC_REG: begin
                            if (index_q == LAST_REG) begin
                                section_d = SEC_MEM;
                                index_d   = '0;
                            end else begin
                                index_d = index_q + IDX_W'(1);
                            end
                        end
                        default: begin
                            if (index_q == LAST_MEM) begin
                                state_d = AFTER_MEM;
                            end else begin
                                index_d = index_q + IDX_W'(1);
                            end
                        end
                    endcase
                end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (tx.tx_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            section_q <= SEC_PC;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            section_q <= section_d;
            index_q   <= index_d;
        end
    end

    debug_word_serializer #(
        .NB_WORD      (NB_WORD),
        .NB_MEM_WIDTH (NB_MEM_WIDTH)
    ) u_serializer (
        .clock      (i_clock),
        .reset      (i_reset),
        .load_i     (serLoad),
        .word_i     (serWord),
        .lastByte_i (serLast),
        .txReady_i  (tx.tx_ready),
        .txData_o   (serData),
        .txValid_o  (serValid),
        .wordLast_o (serWordLast)
    );

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [NB_MEM_WIDTH-1:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (state_q == ST_IDLE && i_start) begin
            xor_d = '0;
        end else if (serValid && tx.tx_ready) begin
            xor_d = xor_q ^ serData;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end

    assign tx.tx_data  = (state_q == ST_CHECKSUM) ? xor_q : serData;
    assign tx.tx_valid = serValid || (state_q == ST_CHECKSUM);
`else
    assign tx.tx_data  = serData;
    assign tx.tx_valid = serValid;
`endif

    assign o_reg_addr        = index_q[NB_REG-1:0];
    assign o_mem_read_enable = (state_q == ST_READ) && (section_q == SEC_MEM);
    assign o_mem_addr        = NB_ADDR'(index_q) << 2;
    assign o_busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_dump_tx.sv
// Self-checking bench for debug_dump_tx: scoreboard of expected dump bytes against the observed stream.
// Honours DEBUG_DUMP_CHECKSUM_EN to expect the trailing XOR byte.
module tb_debug_dump_tx;

    localparam int N_MEM = 32;
    localparam logic [31:0] PC_VALUE = 32'h0000_0040;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int EXP_BYTES = 261;
`else
    localparam int EXP_BYTES = 260;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic [4:0]  regAddr;
    logic [31:0] regData = '0;
    logic        memEn;
    logic [31:0] memAddr;
    logic [31:0] memData = '0;
    logic        busy;
    logic        done;

    debug_dump_tx_if #(.NB_MEM_WIDTH(8)) txIf ();

    debug_dump_tx dut (
        .i_clock           (clock),
        .i_reset           (reset),
        .i_start           (start),
        .i_pc              (pc),
        .o_reg_addr        (regAddr),
        .i_reg_data        (regData),
        .o_mem_read_enable (memEn),
        .o_mem_addr        (memAddr),
        .i_mem_data        (memData),
        .tx                (txIf),
        .o_busy            (busy),
        .o_done            (done)
    );

    always #5 clock = ~clock;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] regBank [32];
    logic [31:0] memArr  [N_MEM];
    logic [7:0]  expQ[$];
    logic [7:0]  gotQ[$];
    logic [31:0] memAddrQ[$];
    int          doneCount = 0;
    int          stableErr = 0;
    int          enableLongErr = 0;
    int          cycleCnt = 0;
    int          lastAcceptCycle = 0;
    int          doneCycle = 0;
    bit          randomReady = 1'b0;

    // Register/memory models answer exactly one cycle after the address is presented
    initial begin
        logic [4:0]  a;
        logic        en;
        logic [31:0] ma;
        forever begin
            @(negedge clock);
            a  = regAddr;
            en = memEn;
            ma = memAddr;
            @(posedge clock);
            #1;
            regData = regBank[a];
            memData = en ? memArr[ma[6:2]] : 32'hDEAD_BEEF;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            txIf.tx_ready = randomReady ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Stream monitor sampling on the falling edge
    bit         prevStall = 1'b0;
    bit         prevEn = 1'b0;
    logic [7:0] prevData = '0;
    always @(negedge clock) begin
        cycleCnt++;
        if (reset) begin
            prevStall = 1'b0;
            prevEn    = 1'b0;
        end else begin
            if (prevStall && (!txIf.tx_valid || txIf.tx_data !== prevData)) stableErr++;
            if (txIf.tx_valid && txIf.tx_ready) begin
                gotQ.push_back(txIf.tx_data);
                lastAcceptCycle = cycleCnt;
            end
            prevStall = txIf.tx_valid && !txIf.tx_ready;
            prevData  = txIf.tx_data;
            if (done) begin
                doneCount++;
                doneCycle = cycleCnt;
            end
            if (memEn) begin
                memAddrQ.push_back(memAddr);
                if (prevEn) enableLongErr++;
            end
            prevEn = memEn;
        end
    end

    task automatic applyStimulus();
        for (int k = 0; k < 32; k++) regBank[k] = k * 32'h0101_0101;
        for (int k = 0; k < N_MEM; k++) memArr[k] = 32'hA000_0000 + k;
        txIf.tx_ready = 1'b1;
    endtask

    task automatic pushExpected();
        logic [31:0] words [$];
        logic [31:0] w;
        logic [7:0]  x;
        x = '0;
        expQ.delete();
        words.push_back(PC_VALUE);
        for (int k = 0; k < 32; k++) words.push_back(k * 32'h0101_0101);
        for (int k = 0; k < N_MEM; k++) words.push_back(32'hA000_0000 + k);
        foreach (words[i]) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                expQ.push_back(w[31 - 8 * b -: 8]);
                x = x ^ w[31 - 8 * b -: 8];
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        expQ.push_back(x);
`endif
    endtask

    task automatic clearScoreboard();
        gotQ.delete();
        memAddrQ.delete();
        doneCount     = 0;
        stableErr     = 0;
        enableLongErr = 0;
    endtask

    task automatic startDump();
        @(posedge clock);
        #1;
        pc    = PC_VALUE;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while (doneCount == 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkCount++;
        if (doneCount == 0) begin
            errorCount++;
            $display("[TB] FAIL %s_timeout: no o_done within %0d cycles, expected a done pulse", name, budget);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkCount++; if (txIf.tx_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_valid: got %b expected 0", txIf.tx_valid); end
        checkCount++; if (txIf.tx_data !== 8'h00) begin errorCount++; $display("[TB] FAIL reset_data: got %h expected 00", txIf.tx_data); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checkCount++; if (done !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checkCount++; if (memEn !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_mem_en: got %b expected 0", memEn); end
        checkCount++; if (regAddr !== 5'd0) begin errorCount++; $display("[TB] FAIL reset_reg_addr: got %0d expected 0", regAddr); end
        checkCount++; if (memAddr !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", memAddr); end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] x;
        clearScoreboard();
        pushExpected();
        startDump();
        @(negedge clock);
        checkCount++; if (txIf.tx_valid !== 1'b1 || busy !== 1'b1) begin errorCount++; $display("[TB] FAIL basic_first_valid: valid=%b busy=%b expected 1 1", txIf.tx_valid, busy); end
        waitDone(5000, "basic");
        checkCount++; if (gotQ.size() != EXP_BYTES) begin errorCount++; $display("[TB] FAIL basic_count: got %0d bytes expected %0d", gotQ.size(), EXP_BYTES); end
        if (gotQ.size() >= 133) begin
            checkCount++; if (gotQ[3] !== 8'h40) begin errorCount++; $display("[TB] FAIL basic_pc_lsb: got %h expected 40", gotQ[3]); end
            checkCount++; if (gotQ[8] !== 8'h01) begin errorCount++; $display("[TB] FAIL basic_r1_msb: got %h expected 01", gotQ[8]); end
            checkCount++; if (gotQ[132] !== 8'hA0) begin errorCount++; $display("[TB] FAIL basic_mem0_msb: got %h expected a0", gotQ[132]); end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (gotQ.size() == 261) begin
            x = '0;
            for (int i = 0; i < 260; i++) x = x ^ gotQ[i];
            checkCount++; if (gotQ[260] !== x) begin errorCount++; $display("[TB] FAIL basic_checksum: got %h expected %h", gotQ[260], x); end
        end
`else
        x = '0;
`endif
        checkCount++; if (doneCycle != lastAcceptCycle + 1) begin errorCount++; $display("[TB] FAIL basic_done_timing: done at %0d expected %0d", doneCycle, lastAcceptCycle + 1); end
        checkCount++; if (doneCount != 1) begin errorCount++; $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCount); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
        for (int i = 0; expQ.size() > 0 && gotQ.size() > 0; i++) begin
            logic [7:0] e, g;
            e = expQ.pop_front();
            g = gotQ.pop_front();
            checkCount++; if (g !== e) begin errorCount++; $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_read_interface();
        clearScoreboard();
        pushExpected();
        startDump();
        waitDone(5000, "readif");
        checkCount++; if (memAddrQ.size() != N_MEM) begin errorCount++; $display("[TB] FAIL readif_strobes: got %0d expected %0d", memAddrQ.size(), N_MEM); end
        for (int k = 0; k < N_MEM && k < memAddrQ.size(); k++) begin
            checkCount++; if (memAddrQ[k] !== 32'(k * 4)) begin errorCount++; $display("[TB] FAIL readif_addr%0d: got %h expected %h", k, memAddrQ[k], k * 4); end
        end
        checkCount++; if (enableLongErr != 0) begin errorCount++; $display("[TB] FAIL readif_strobe_width: %0d multi-cycle strobes expected 0", enableLongErr); end
        for (int i = 0; expQ.size() > 0 && gotQ.size() > 0; i++) begin
            logic [7:0] e, g;
            e = expQ.pop_front();
            g = gotQ.pop_front();
            checkCount++; if (g !== e) begin errorCount++; $display("[TB] FAIL readif_byte%0d: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_backpressure();
        clearScoreboard();
        pushExpected();
        randomReady = 1'b1;
        startDump();
        waitDone(8000, "backpressure");
        randomReady = 1'b0;
        checkCount++; if (gotQ.size() != EXP_BYTES) begin errorCount++; $display("[TB] FAIL bp_count: got %0d bytes expected %0d", gotQ.size(), EXP_BYTES); end
        checkCount++; if (stableErr != 0) begin errorCount++; $display("[TB] FAIL bp_stable: %0d unstable stalls expected 0", stableErr); end
        checkCount++; if (doneCount != 1) begin errorCount++; $display("[TB] FAIL bp_done_count: got %0d expected 1", doneCount); end
        for (int i = 0; expQ.size() > 0 && gotQ.size() > 0; i++) begin
            logic [7:0] e, g;
            e = expQ.pop_front();
            g = gotQ.pop_front();
            checkCount++; if (g !== e) begin errorCount++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_reset_mid_dump();
        int n = 0;
        clearScoreboard();
        startDump();
        while (!(gotQ.size() >= 70 && txIf.tx_valid) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkCount++; if (n >= 2000) begin errorCount++; $display("[TB] FAIL midreset_reach: stream stalled at %0d bytes expected 70", gotQ.size()); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkCount++; if (txIf.tx_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_valid: got %b expected 0", txIf.tx_valid); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        checkCount++; if (done !== 1'b0 || doneCount != 0) begin errorCount++; $display("[TB] FAIL midreset_done: done=%b count=%0d expected 0", done, doneCount); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        clearScoreboard();
        pushExpected();
        startDump();
        waitDone(5000, "midreset");
        checkCount++; if (gotQ.size() != EXP_BYTES) begin errorCount++; $display("[TB] FAIL midreset_count: got %0d bytes expected %0d", gotQ.size(), EXP_BYTES); end
        for (int i = 0; expQ.size() > 0 && gotQ.size() > 0; i++) begin
            logic [7:0] e, g;
            e = expQ.pop_front();
            g = gotQ.pop_front();
            checkCount++; if (g !== e) begin errorCount++; $display("[TB] FAIL midreset_byte%0d: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_start_while_busy();
        int n = 0;
        clearScoreboard();
        pushExpected();
        startDump();
        while (gotQ.size() < 10 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        checkCount++; if (n >= 5000) begin errorCount++; $display("[TB] FAIL busy_done_timeout: no o_done within %0d cycles, expected a done pulse", n); end
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clock);
        checkCount++; if (busy !== 1'b0 || txIf.tx_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL busy_restart: busy=%b valid=%b expected 0 0", busy, txIf.tx_valid); end
        checkCount++; if (doneCount != 1) begin errorCount++; $display("[TB] FAIL busy_done_count: got %0d expected 1", doneCount); end
        checkCount++; if (gotQ.size() != EXP_BYTES) begin errorCount++; $display("[TB] FAIL busy_count: got %0d bytes expected %0d", gotQ.size(), EXP_BYTES); end
        for (int i = 0; expQ.size() > 0 && gotQ.size() > 0; i++) begin
            logic [7:0] e, g;
            e = expQ.pop_front();
            g = gotQ.pop_front();
            checkCount++; if (g !== e) begin errorCount++; $display("[TB] FAIL busy_byte%0d: got %h expected %h", i, g, e); end
        end
    endtask

    initial begin
        applyStimulus();
        test_reset();
        test_basic();
        test_read_interface();
        test_backpressure();
        test_reset_mid_dump();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/debug_dump_tx.md
Name: debug_dump_tx

Overview:
- Debug-unit transmit side: after the pipeline halts, reads PC, the 32-entry register bank and the first N_MEM_WORDS data-memory words.
- Serializes them into a byte stream over a valid/ready interface to the UART transmitter.
- Counterpart to the byte-wide debug write path that loads instruction memory: the same interface run in the outbound direction.

Parameters:
- NB_PC, 32, PC width (multiple of 8)
- NB_DATA, 32, register/memory word width (multiple of 8)
- NB_REG, 5, register-bank address width; 2**NB_REG registers dumped
- NB_ADDR, 32, data-memory byte address width
- NB_MEM_WIDTH, 8, stream byte width
- N_MEM_WORDS, 32, data-memory words dumped (>=1)

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  one-cycle dump request (pipeline halted)
- i_pc  in  NB_PC  current PC, sampled on accepted i_start
- o_reg_addr  out  NB_REG  register-bank read address
- i_reg_data  in  NB_DATA  register read data, valid 1 cycle after o_reg_addr
- o_mem_read_enable  out  1  data-memory read strobe
- o_mem_addr  out  NB_ADDR  data-memory byte address (word index*4)
- i_mem_data  in  NB_DATA  memory read data, valid 1 cycle after strobe
- o_tx_data  out  NB_MEM_WIDTH  stream byte
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  UART can accept byte
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse, last byte accepted

Behaviour:
- Reset values: o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0, o_mem_read_enable=0, o_reg_addr=0, o_mem_addr=0; FSM=IDLE.
- Stream order: PC, then R0..R31, then MEM[0..N_MEM_WORDS-1]. Each word sent MSB byte first. Default total = 4+128+128 = 260 bytes.
- Transfer: a byte is accepted on a rising edge with o_tx_valid&&i_tx_ready. While valid&&!ready, o_tx_data is held stable and valid stays high.
- FSM states: IDLE, CAPTURE_PC, READ, WAIT, SEND, DONE (plus CHECKSUM, optional).
- IDLE: i_start=1 latches i_pc into the shift register, o_busy=1 and goes to SEND (section=PC). o_tx_valid rises the cycle after i_start.
- READ: drives o_reg_addr=index (REG section) or o_mem_read_enable=1, o_mem_addr=index<<2 (MEM section); goes to WAIT.
- WAIT: captures i_reg_data/i_mem_data into the shift register; goes to SEND. o_mem_read_enable is high only in READ.
- SEND: o_tx_valid=1; on each accept, shift left NB_MEM_WIDTH and increment the byte counter (0..NB_DATA/8-1).
- After the last byte of a word:
  - If more words remain in the section: index+1, go to READ.
  - Otherwise go to the next section with index=0: PC→REG→MEM→DONE.
- Inter-word gap: 2 idle cycles on the stream (READ, WAIT).
- DONE: o_done=1 for one cycle, o_busy=0, return to IDLE.
- i_start while o_busy=1 is ignored; i_start in the DONE cycle is ignored.
- Reset mid-dump (including mid-byte with valid high): next cycle valid=0, no o_done, IDLE. The partial stream is not resumed.
- Index counter wraps only by section change; width = max(NB_REG, clog2(N_MEM_WORDS))+1.

Optional Feature:
- Macro DEBUG_DUMP_CHECKSUM_EN.
- Defined: after the last MEM byte, state CHECKSUM sends one extra byte, the XOR of all preceding payload bytes (PC included). The running XOR clears on accepted i_start. o_done follows acceptance of the checksum byte; default total 261 bytes.
- Undefined: no CHECKSUM state and no XOR register; o_done follows the last MEM byte.

Decomposition:
- Shared debug package holds: state encoding localparams, section encoding (SEC_PC, SEC_REG, SEC_MEM), and BYTES_PER_WORD = NB_DATA/NB_MEM_WIDTH. The debug receive/load logic reuses the same package.
- One natural sub-module: debug_word_serializer (load word, shift out bytes under valid/ready, pulse word_last).

Test Plan:
- Basic dump, always-ready: PC=0x0000_0040, Rk=k*0x01010101, MEM[k]=0xA0000000+k; i_start → exactly 260 bytes.
  - Bytes 0..3 = 00 00 00 40; bytes 4..7 = 00 00 00 00; bytes 8..11 = 01 01 01 01; byte 132 = A0.
  - o_done one cycle after the 260th accept.
- Backpressure: toggle i_tx_ready randomly 30% low → identical 260-byte sequence, o_tx_data stable whenever valid&&!ready, no duplicates/drops.
- Read interface: check o_mem_addr sequence 0x00,0x04,...,0x7C. Each o_mem_read_enable is one cycle. o_reg_addr steps 0..31. Data is sampled exactly 1 cycle after the address.
- Reset mid-dump: assert i_reset at byte 70 with valid high → next cycle valid=0, busy=0, no done. A subsequent i_start produces the full stream from PC byte 0.
- Start while busy: pulse i_start at byte 10 and in the DONE cycle → stream unchanged, single o_done.
- With DEBUG_DUMP_CHECKSUM_EN: same data as the basic dump → 261 bytes, last byte = XOR of bytes 0..259, done after it.
